// File: rtl/rom_id_controller.sv
// Sweeps an 8 x 16-bit ID ROM once after reset and presents each ID with a valid strobe and index.
// Latency: address before edge k shows up on q after edge k+1; the first ID appears after edge 2.
// No backpressure: downstream must capture q on every cycle q_valid is high.
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous, active-low reset
//   address  controller ROM address (0..7, parks at 7)
//   q        registered ROM read data
//   q_valid  one-cycle strobe per scanned entry
//   q_index  address whose data is on q
//   done     high once every entry has been presented
module rom_id_controller #(
  parameter int                 ADDR_W     = 3,
  parameter int                 DATA_W     = 16,
  parameter logic [DATA_W-1:0]  ROM_INIT_0 = 16'h1111,
  parameter logic [DATA_W-1:0]  ROM_INIT_1 = 16'h2222,
  parameter logic [DATA_W-1:0]  ROM_INIT_2 = 16'h3333,
  parameter logic [DATA_W-1:0]  ROM_INIT_3 = 16'h4444,
  parameter logic [DATA_W-1:0]  ROM_INIT_4 = 16'h5555,
  parameter logic [DATA_W-1:0]  ROM_INIT_5 = 16'h6666,
  parameter logic [DATA_W-1:0]  ROM_INIT_6 = 16'h7777,
  parameter logic [DATA_W-1:0]  ROM_INIT_7 = 16'h8888
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] q,
  output logic              q_valid,
  output logic [ADDR_W-1:0] q_index,
  output logic              done
);

  localparam logic [1:0] SCAN  = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  logic [1:0]        state;
  logic              drain_cnt;
  logic [ADDR_W-1:0] rom_addr;   // ROM address register (first pipeline stage)
  logic              rom_vld;    // rom_addr holds an address that must be reported
  logic [DATA_W-1:0] rom_dat;
  logic [DATA_W-1:0] rom [8];

  assign rom[0] = ROM_INIT_0;
  assign rom[1] = ROM_INIT_1;
  assign rom[2] = ROM_INIT_2;
  assign rom[3] = ROM_INIT_3;
  assign rom[4] = ROM_INIT_4;
  assign rom[5] = ROM_INIT_5;
  assign rom[6] = ROM_INIT_6;
  assign rom[7] = ROM_INIT_7;

  assign rom_dat = rom[rom_addr];

  // Controller: address walks 0..7 in SCAN; DRAIN lasts two cycles so the
  // last address (7) is issued once and then flushed through the pipeline.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= SCAN;
      address   <= '0;
      drain_cnt <= 1'b0;
    end else begin
      case (state)
        SCAN: begin
          address <= address + 1'b1;
          if (address == LAST_ADDR - 1'b1) state <= DRAIN;
        end
        DRAIN: begin
          drain_cnt <= 1'b1;
          if (drain_cnt) state <= DONE;
        end
        DONE: state <= DONE;
        default: state <= SCAN;
      endcase
    end
  end

  // Read pipeline. Only issued addresses load the output register, so q
  // stays at 0 until the first ID and holds the last ID once done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rom_addr <= '0;
      rom_vld  <= 1'b0;
      q        <= '0;
      q_valid  <= 1'b0;
      q_index  <= '0;
      done     <= 1'b0;
    end else begin
      rom_addr <= address;
      rom_vld  <= (state == SCAN) || ((state == DRAIN) && !drain_cnt);
      q_valid  <= rom_vld;
      if (rom_vld) begin
        q       <= rom_dat;
        q_index <= rom_addr;
      end
      done <= (state == DONE);
    end
  end

endmodule

// File: tb/tb_rom_id_controller.sv
// Bench for rom_id_controller: a default-contents instance and one with entry 3 overridden.
// Reference model derives every output from the number of edges since reset release.
// Reset is asserted asynchronously at random points, including during DONE.
module tb_rom_id_controller;

  logic        clk;
  logic        rst;
  logic [2:0]  address_a, address_b;
  logic [15:0] q_a, q_b;
  logic        q_valid_a, q_valid_b;
  logic [2:0]  q_index_a, q_index_b;
  logic        done_a, done_b;

  int checks = 0;
  int errors = 0;
  int n      = 0;   // rising edges since reset release

  logic [15:0] rom_def [8];
  logic [15:0] rom_ovr [8];

  rom_id_controller u_def (
    .clk(clk), .rst(rst), .address(address_a), .q(q_a),
    .q_valid(q_valid_a), .q_index(q_index_a), .done(done_a)
  );

  rom_id_controller #(.ROM_INIT_3(16'hBEEF)) u_ovr (
    .clk(clk), .rst(rst), .address(address_b), .q(q_b),
    .q_valid(q_valid_b), .q_index(q_index_b), .done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s n=%0d observed=%h expected=%h", tag, n, obs, exp);
    end
  endtask

  function automatic int min7(input int v);
    return (v > 7) ? 7 : v;
  endfunction

  task automatic check_all();
    logic [15:0] eq_a, eq_b;
    logic [2:0]  eidx;
    eq_a = (n < 2) ? 16'h0 : rom_def[min7(n - 2)];
    eq_b = (n < 2) ? 16'h0 : rom_ovr[min7(n - 2)];
    eidx = (n < 2) ? 3'd0 : 3'(min7(n - 2));
    chk("address_a", 32'(address_a), 32'(min7(n)));
    chk("q_a",       32'(q_a),       32'(eq_a));
    chk("q_valid_a", 32'(q_valid_a), 32'(n >= 2 && n <= 9));
    chk("q_index_a", 32'(q_index_a), 32'(eidx));
    chk("done_a",    32'(done_a),    32'(n >= 10));
    chk("address_b", 32'(address_b), 32'(min7(n)));
    chk("q_b",       32'(q_b),       32'(eq_b));
    chk("q_valid_b", 32'(q_valid_b), 32'(n >= 2 && n <= 9));
    chk("done_b",    32'(done_b),    32'(n >= 10));
  endtask

  // One rising edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    if (rst) n++;
    #1;
    check_all();
  endtask

  task automatic run(input int edges);
    for (int i = 0; i < edges; i++) step();
  endtask

  // Called just after a sampling point: drops reset between edges and
  // checks the outputs cleared before any further clock edge.
  task automatic async_reset(input int hold);
    #2 rst = 1'b0;
    #1 n = 0;
    check_all();
    run(hold);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      rom_def[i] = 16'((i + 1) * 16'h1111);
      rom_ovr[i] = rom_def[i];
    end
    rom_ovr[3] = 16'hBEEF;

    rst = 1'b0;
    #1 check_all();
    run(5);
    @(negedge clk);
    rst = 1'b1;

    // Full sweep plus 20 edges past edge 10.
    run(30);

    // Abort after edge 5, then a full sweep from scratch.
    async_reset(0);
    run(5);
    async_reset($urandom_range(1, 6));
    run(30);

    // Random abort points (any state, including DONE) and hold lengths.
    for (int r = 0; r < 6; r++) begin
      async_reset($urandom_range(0, 8));
      run($urandom_range(1, 16));
    end

    // Reset during DONE, then a second complete sweep.
    run(12);
    async_reset($urandom_range(1, 4));
    run(25);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
